mips16_muldiv: RTL
==================

// Module: mips16_muldiv
// PURPOSE
//   Iterative multiply/divide unit for the 16-bit MIPS datapath. It handles the operations the
//   single-cycle ALU cannot: signed and unsigned mult/div, producing a HI/LO pair.
//   Decode issues the operation with a start/busy/done handshake.
//   Writeback reads hi/lo when done pulses. The pipeline stalls while busy is high.
// PARAMETERS
//   WIDTH  16  operand width; hi and lo are each WIDTH bits; iteration count = WIDTH
// PORTS
//   clk          in   1      clock; all state changes on its rising edge
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      request; sampled only when busy=0
//   op           in   2      00 mult (signed), 01 multu, 10 div (signed), 11 divu
//   a            in   WIDTH  multiplicand / dividend, captured with start
//   b            in   WIDTH  multiplier / divisor, captured with start
//   cancel       in   1      abort the current operation (pipeline flush)
//   busy         out  1      operation in progress
//   done         out  1      one-cycle pulse: hi/lo/div_by_zero valid
//   hi           out  WIDTH  mult: upper product half; div: remainder
//   lo           out  WIDTH  mult: lower product half; div: quotient
//   div_by_zero  out  1      last div/divu had b==0; held with hi/lo
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; busy, done, div_by_zero = 0; hi, lo = 0; counter = 0.
//     Reset mid-operation discards all work and produces no done pulse.
//   FSM: IDLE -> RUN on start; RUN -> DONE after WIDTH cycles; DONE -> IDLE,
//        or DONE -> RUN if start is high in DONE (back-to-back issue).
//   Timing, with E0 = the edge that samples start:
//     - op, a and b are latched at E0.
//     - busy=1 from E0 through edge E_WIDTH (WIDTH cycles).
//     - hi/lo/div_by_zero are written at E_WIDTH.
//     - done=1, busy=0 for the single cycle after E_WIDTH.
//   Operand stability: a and b may change after E0 without effect. start while busy=1 is ignored.
//   Outputs hold: hi, lo and div_by_zero hold their values until the next completed
//     operation; they never show partial results.
//   Signed ops: operate on magnitudes, then fix signs at completion.
//     - product sign = sign(a) XOR sign(b);
//     - quotient sign = sign(a) XOR sign(b);
//     - remainder sign = sign(a) (truncating division, C semantics).
//   Multiply: shift-add, one multiplier bit per cycle; 2*WIDTH-bit result {hi,lo}, exact.
//   Divide: restoring, one quotient bit per cycle; WIDTH+1-bit partial remainder.
//   Divide by zero (b==0): full latency is still spent; result lo=all-ones, hi=a, div_by_zero=1.
//     Mult and any div with b!=0 clear div_by_zero.
//   Signed overflow (div, a=most-negative, b=-1): lo=a (0x8000 at WIDTH=16), hi=0, div_by_zero=0.
//   Cancel:
//     - cancel=1 in RUN: next state IDLE, busy=0, no done, hi/lo unchanged.
//     - cancel together with start in IDLE: start is ignored.
//     - cancel in DONE: done still pulses and results stand.
//   Counter counts 0..WIDTH-1, no wrap beyond. done never asserts without a preceding accepted start.
// TESTING
//   mult a=0xFFFD(-3) b=0x0007 -> after 16 busy cycles done=1, hi=0xFFFF lo=0xFFEB
//   multu a=0xFFFF b=0xFFFF -> hi=0xFFFE lo=0x0001; back-to-back start in DONE cycle accepted
//   div a=0xFFF9(-7) b=0x0002 -> lo=0xFFFD(-3) hi=0xFFFF(-1); div a=0x8000 b=0xFFFF -> lo=0x8000 hi=0
//   divu a=0x0064 b=0 -> div_by_zero=1 lo=0xFFFF hi=0x0064; next divu 100/7 -> lo=14 hi=2, flag clear
//   start at cycle 0, cancel at cycle 5 -> busy falls after that edge, no done, hi/lo keep old values
//   rst_n low at cycle 8 of a mult -> all outputs 0 immediately (async); new start afterwards completes normally

Source files
------------

// File: rtl/mips16_muldiv_if.sv
// Purpose: request/response bundle between decode/writeback and the mult/div unit.
// Latency: n/a (signal grouping only).
// Backpressure: busy holds off new requests; done marks valid hi/lo/div_by_zero.
interface mips16_muldiv_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    // Issuing side: decode drives the request, writeback consumes the result.
    modport master (
        output start, op, a, b, cancel,
        input  busy, done, hi, lo, div_by_zero
    );

    // The iterative unit itself.
    modport slave (
        input  start, op, a, b, cancel,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/mips16_muldiv.sv
// Purpose: iterative signed/unsigned multiply and restoring divide producing a HI/LO pair.
// Latency: WIDTH cycles busy after the accepting edge, then a one-cycle done pulse.
// Backpressure: start is ignored while busy; cancel aborts a running op without done.
module mips16_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mips16_muldiv_if.slave    bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_q;
    logic             neg_a, neg_b, b_zero;
    logic [WIDTH-1:0] a_q, mag_a, mag_b;
    // Mult: {partial product upper, multiplier shifting out}.
    // Div:  {partial remainder (WIDTH+1), dividend shifting out / quotient shifting in}.
    logic [2*WIDTH:0] acc, acc_step;

    logic             accept, last;
    logic             neg_a_in, neg_b_in;
    logic [WIDTH-1:0] mag_a_in, mag_b_in;
    logic [WIDTH:0]   add_sum, rem_sh;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             res_dbz;

    // A request is taken only when idle or finishing; a concurrent flush wins.
    assign accept = bus.start && !bus.cancel && (state == ST_IDLE || state == ST_DONE);
    assign last   = (state == ST_RUN) && !bus.cancel && (cnt == CW'(WIDTH - 1));

    assign bus.busy = (state == ST_RUN);
    assign bus.done = (state == ST_DONE);

    // Signed ops work on magnitudes; the signs are remembered for the final fixup.
    assign neg_a_in = !bus.op[0] && bus.a[WIDTH-1];
    assign neg_b_in = !bus.op[0] && bus.b[WIDTH-1];
    assign mag_a_in = neg_a_in ? -bus.a : bus.a;
    assign mag_b_in = neg_b_in ? -bus.b : bus.b;

    // One iteration: shift-add for multiply, compare-subtract for divide.
    always_comb begin
        add_sum  = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mag_a} : '0);
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        acc_step = {1'b0, add_sum, acc[WIDTH-1:1]};
        if (op_q[1]) begin
            if (rem_sh >= {1'b0, mag_b}) begin
                acc_step = {rem_sh - {1'b0, mag_b}, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {rem_sh, acc[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Final result from the last iteration, with sign and divide-by-zero fixups.
    always_comb begin
        prod    = acc_step[2*WIDTH-1:0];
        quo     = acc_step[WIDTH-1:0];
        rem     = acc_step[2*WIDTH-1:WIDTH];
        res_dbz = 1'b0;
        if (!op_q[1]) begin
            if (neg_a ^ neg_b) prod = -prod;
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (b_zero) begin
            res_hi  = a_q;
            res_lo  = '1;
            res_dbz = 1'b1;
        end else begin
            res_lo = (neg_a ^ neg_b) ? -quo : quo;
            res_hi = neg_a ? -rem : rem;
        end
    end

    // Control FSM and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (bus.cancel) begin
                        state <= ST_IDLE;
                    end else if (last) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Operand capture on accept, then one iteration per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            a_q    <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            b_zero <= 1'b0;
            mag_a  <= '0;
            mag_b  <= '0;
            acc    <= '0;
        end else if (accept) begin
            op_q   <= bus.op;
            a_q    <= bus.a;
            neg_a  <= neg_a_in;
            neg_b  <= neg_b_in;
            b_zero <= (bus.b == '0);
            mag_a  <= mag_a_in;
            mag_b  <= mag_b_in;
            acc    <= {{(WIDTH+1){1'b0}}, bus.op[1] ? mag_a_in : mag_b_in};
        end else if (state == ST_RUN) begin
            acc <= acc_step;
        end
    end

    // Architectural results change only when an operation completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.hi          <= '0;
            bus.lo          <= '0;
            bus.div_by_zero <= 1'b0;
        end else if (last) begin
            bus.hi          <= res_hi;
            bus.lo          <= res_lo;
            bus.div_by_zero <= res_dbz;
        end
    end
endmodule
